jparity_checker: RTL and testbench
==================================

# jparity_checker

Serial receiver and even-parity checker at the far end of the parity-generator link. It accepts a bit stream of frames, each DW data bits MSB-first followed by one even-parity bit (the serialised form of {data, parity}). It reassembles each frame, checks parity, and presents the data word with an error flag on a valid/ready output port. It sits between the serial line interface and the word-level consumer.

## Interface
- DW, default 4: data bits per frame; the frame length is DW+1.
- CW, default 8: width of the error counter (only used with JPARITY_ERRCNT_EN).
- CLK, input, 1: single clock; all state updates on the rising edge.
- RST_N, input, 1: reset, **asynchronous, active-low**.
- SIN, input, 1: serial data bit.
- SVALID, input, 1: SIN holds a valid bit this cycle.
- SREADY, output, 1: the checker accepts SIN this cycle.
- DOUT, output, DW: received data word.
- PERR, output, 1: parity error for the frame on DOUT; valid only while DVALID is 1.
- DVALID, output, 1: DOUT/PERR hold a completed frame.
- DREADY, input, 1: consumer takes the frame.
- ERRCNT, output, CW: saturating count of frames with errors. Present only with JPARITY_ERRCNT_EN.

## Operation
- Bit transfer: a bit moves when SVALID && SREADY at a rising edge. No other cycle changes the receive state.
- FSM states:
  - DATA: bit counter BC runs 0..DW-1. Each accepted bit shifts into the shift register (MSB first) and XORs into the running parity flop ACC.
  - PAR: BC == DW; the next accepted bit is the parity bit.
- Transitions:
  - DATA→PAR after the DW-th data bit.
  - PAR→DATA on acceptance of the parity bit. At that point BC=0 and ACC=0.
- Frame completion (parity bit accepted):
  - DOUT ← shift register.
  - PERR ← ACC ^ SIN (1 means odd count of ones, i.e. an error).
  - DVALID ← 1.
- Output handshake:
  - DVALID && DREADY at an edge clears DVALID, unless a frame completes on the same edge.
  - DOUT and PERR are stable while DVALID=1 and DREADY=0.
- SREADY:
  - In DATA: SREADY = 1 (data bits shift into a separate register, so DOUT is never disturbed).
  - In PAR: SREADY = !DVALID || DREADY.
  - SREADY is combinational from DVALID and DREADY only, never from SVALID.
- Simultaneous events: a parity bit accepted in the same edge as DVALID && DREADY loads the new frame and keeps DVALID=1. No bubble, no loss.
- Idle: SVALID=0 holds all state; there is no timeout.

## Timing
- Reset values: DOUT=0, PERR=0, DVALID=0, ERRCNT=0, state DATA, BC=0, ACC=0. SREADY=1 during and after reset.
- Reset asserted mid-frame discards the partial frame and any held output word immediately (asynchronous).
- Latency: DVALID rises on the edge that accepts the parity bit and is visible the cycle after.
- Throughput: one frame per DW+1 accepted bits, with no dead cycles when DREADY=1.
- Backpressure: with DVALID=1 and DREADY=0, the receiver absorbs up to DW further data bits, then stalls at PAR with SREADY=0.

## Configuration
- JPARITY_ERRCNT_EN defined:
  - The ERRCNT port and a CW-bit counter exist.
  - The counter increments by 1 on each frame completion with PERR=1, exactly once per frame, regardless of DREADY.
  - It saturates at 2^CW-1 and is cleared only by RST_N.
- Not defined: no ERRCNT port and no counter logic. All other behaviour is identical.

## Structure
- Shared package jparity_pkg holds:
  - The state enum {DATA, PAR}.
  - A function for the frame length (DW+1).
  - The even-parity convention constant, shared with the generator.
- No sub-module. Shift register, BC, ACC, output register and counter live in one module. ACC is a single running XOR flop, not a reduction over a stored frame.

## Test plan
All scenarios use DW=4 and CW=8.
- Stream 0,0,1,1 then parity 0 with DREADY=1 → DVALID for one cycle, DOUT=4'b0011, PERR=0, ERRCNT=0.
- Stream 1,0,1,1 then parity 1 → DOUT=4'b1011, PERR=0. The same frame with parity 0 → DOUT=4'b1011, PERR=1, ERRCNT=1.
- Stream 1,1,1,1 then parity 0 with DREADY=0 → DVALID held. The next frame's 4 data bits are accepted, SREADY=0 at its parity bit, and DOUT=4'b1111 is stable. Raise DREADY → the parity bit is accepted on the same edge, the second frame is loaded, and DVALID stays 1.
- Back-to-back frames with SVALID=1 and DREADY=1 continuously → one DVALID pulse every 5 cycles, with no gaps or lost frames.
- Assert RST_N low after 2 data bits and with a held output word → DVALID=0, DOUT=0, ERRCNT=0 immediately. The next full frame 0011/0 is received correctly.
- 300 consecutive bad-parity frames → ERRCNT saturates at 255.

Source files
------------

// File: rtl/jparity_pkg.sv
// Shared definitions for the serial even-parity link: receiver FSM states,
// frame length helper and the parity convention used by both link ends.
package jparity_pkg;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_PAR  = 1'b1
  } state_e;

  // XOR over a complete frame {data, parity} equals this value when the frame is good.
  localparam logic EVEN_PARITY = 1'b0;

  function automatic int unsigned frame_len(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/jparity_checker_if.sv
// Serial input and word-level output port bundle of the parity checker.
interface jparity_checker_if #(
  parameter int DW = 4
);
  logic          sin;
  logic          svalid;
  logic          sready;
  logic [DW-1:0] dout;
  logic          perr;
  logic          dvalid;
  logic          dready;

  modport master (
    output sin, svalid, dready,
    input  sready, dout, perr, dvalid
  );

  modport slave (
    input  sin, svalid, dready,
    output sready, dout, perr, dvalid
  );
endinterface

// File: rtl/jparity_checker.sv
// Serial frame receiver and even-parity checker; define JPARITY_ERRCNT_EN
// to add the saturating error-frame counter output errcnt.
module jparity_checker
  import jparity_pkg::*;
#(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef JPARITY_ERRCNT_EN
  output logic [CW-1:0] errcnt,
`endif
  jparity_checker_if.slave bus
);

  localparam int BCW = $clog2(frame_len(DW));

  if (DW < 1 || CW < 1) begin : g_cfg_check
    $error("jparity_checker: DW and CW must both be at least 1");
  end

  state_e          state, state_nxt;
  logic [BCW-1:0]  bc, bc_nxt;
  logic            acc, acc_nxt;
  logic [DW-1:0]   shreg, shreg_nxt;
  logic            frame_done;
  logic            perr_nxt;
  logic            accept;

  logic [DW-1:0]   dout_q;
  logic            perr_q;
  logic            dvalid_q;

  assign accept = bus.svalid && bus.sready;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    bc_nxt     = bc;
    acc_nxt    = acc;
    shreg_nxt  = shreg;
    frame_done = 1'b0;
    bus.sready = 1'b1;

    unique case (state)
      ST_DATA: begin
        if (accept) begin
          shreg_nxt = DW'({shreg, bus.sin});
          acc_nxt   = acc ^ bus.sin;
          if (bc == BCW'(DW - 1)) begin
            state_nxt = ST_PAR;
            bc_nxt    = BCW'(DW);
          end else begin
            bc_nxt = bc + 1'b1;
          end
        end
      end
      ST_PAR: begin
        // The output register may only be overwritten once the held word leaves.
        bus.sready = !dvalid_q || bus.dready;
        if (accept) begin
          frame_done = 1'b1;
          state_nxt  = ST_DATA;
          bc_nxt     = '0;
          acc_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_DATA;
        bc_nxt    = '0;
        acc_nxt   = 1'b0;
      end
    endcase
  end

  assign perr_nxt = acc ^ bus.sin ^ EVEN_PARITY;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_DATA;
      bc    <= '0;
      acc   <= 1'b0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      bc    <= bc_nxt;
      acc   <= acc_nxt;
      shreg <= shreg_nxt;
    end
  end

  // A completing frame wins over the consumer's take, so back-to-back words never bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      perr_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else if (frame_done) begin
      dout_q   <= shreg;
      perr_q   <= perr_nxt;
      dvalid_q <= 1'b1;
    end else if (dvalid_q && bus.dready) begin
      dvalid_q <= 1'b0;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.perr   = perr_q;
  assign bus.dvalid = dvalid_q;

`ifdef JPARITY_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt <= '0;
    end else if (frame_done && perr_nxt && (errcnt != {CW{1'b1}})) begin
      errcnt <= errcnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jparity_checker.sv
// Directed self-checking bench for jparity_checker with DW=4, CW=8.
module tb_jparity_checker;

  localparam int DW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  jparity_checker_if #(.DW(DW)) bus ();

`ifdef JPARITY_ERRCNT_EN
  logic [CW-1:0] errcnt;
`endif

  jparity_checker #(.DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef JPARITY_ERRCNT_EN
    .errcnt(errcnt),
`endif
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the bit is accepted.
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bus.sin    = b;
    bus.svalid = 1'b1;
    while (bus.sready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_assert++;
      n_fail++;
      $error("FAIL sready_timeout: observed sready=%b expected 1 within 20 cycles", bus.sready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic par);
    for (int i = DW - 1; i >= 0; i--) send_bit(data[i]);
    send_bit(par);
  endtask

  logic [DW-1:0] b2b_data [3] = '{4'b0110, 4'b1000, 4'b0111};
  logic          b2b_par  [3] = '{1'b0, 1'b1, 1'b0};
  logic          b2b_perr [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    // Reset state
    bus.sin    = 1'b0;
    bus.svalid = 1'b0;
    bus.dready = 1'b1;
    rst_n      = 1'b0;
    #2;
    chk("rst_sready", bus.sready, 1);
    chk("rst_dvalid", bus.dvalid, 0);
    chk("rst_dout",   bus.dout,   0);
    chk("rst_perr",   bus.perr,   0);
`ifdef JPARITY_ERRCNT_EN
    chk("rst_errcnt", errcnt, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Good frame 0011/0, single-cycle DVALID
    send_frame(4'b0011, 1'b0);
    bus.svalid = 1'b0;
    chk("f1_dvalid", bus.dvalid, 1);
    chk("f1_dout",   bus.dout,   4'b0011);
    chk("f1_perr",   bus.perr,   0);
`ifdef JPARITY_ERRCNT_EN
    chk("f1_errcnt", errcnt, 0);
`endif
    @(negedge clk);
    chk("f1_dvalid_drop", bus.dvalid, 0);

    // 1011 with correct then wrong parity
    send_frame(4'b1011, 1'b1);
    chk("f2_dout", bus.dout, 4'b1011);
    chk("f2_perr", bus.perr, 0);
    send_frame(4'b1011, 1'b0);
    bus.svalid = 1'b0;
    chk("f3_dvalid", bus.dvalid, 1);
    chk("f3_dout",   bus.dout,   4'b1011);
    chk("f3_perr",   bus.perr,   1);
`ifdef JPARITY_ERRCNT_EN
    chk("f3_errcnt", errcnt, 1);
`endif
    @(negedge clk);

    // Backpressure: hold 1111, absorb 0101 data bits, stall at parity
    bus.dready = 1'b0;
    send_frame(4'b1111, 1'b0);
    chk("bp_dvalid", bus.dvalid, 1);
    chk("bp_dout",   bus.dout,   4'b1111);
    chk("bp_perr",   bus.perr,   0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.sin    = 1'b0;
    bus.svalid = 1'b1;
    chk("bp_stall_sready", bus.sready, 0);
    chk("bp_stall_dout",   bus.dout,   4'b1111);
    chk("bp_stall_dvalid", bus.dvalid, 1);
    @(negedge clk);
    chk("bp_stall2_sready", bus.sready, 0);
    chk("bp_stall2_dout",   bus.dout,   4'b1111);
    bus.dready = 1'b1;
    #1;
    chk("bp_release_sready", bus.sready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.svalid = 1'b0;
    chk("bp_next_dvalid", bus.dvalid, 1);
    chk("bp_next_dout",   bus.dout,   4'b0101);
    chk("bp_next_perr",   bus.perr,   0);
    @(negedge clk);
    chk("bp_next_drop", bus.dvalid, 0);

    // Back-to-back frames, DVALID exactly on every 5th accepted bit
    c0 = cyc;
    for (int f = 0; f < 3; f++) begin
      for (int i = DW - 1; i >= 0; i--) begin
        send_bit(b2b_data[f][i]);
        chk($sformatf("b2b%0d_bit%0d_dvalid", f, i), bus.dvalid, 0);
      end
      send_bit(b2b_par[f]);
      chk($sformatf("b2b%0d_dvalid", f), bus.dvalid, 1);
      chk($sformatf("b2b%0d_dout", f),   bus.dout,   b2b_data[f]);
      chk($sformatf("b2b%0d_perr", f),   bus.perr,   b2b_perr[f]);
    end
    bus.svalid = 1'b0;
    chk("b2b_cycles", cyc - c0, 15);
`ifdef JPARITY_ERRCNT_EN
    chk("b2b_errcnt", errcnt, 2);
`endif
    @(negedge clk);

    // Asynchronous reset mid-frame with a held word
    bus.dready = 1'b0;
    send_frame(4'b0110, 1'b0);
    chk("mr_held_dvalid", bus.dvalid, 1);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.svalid = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("mr_dvalid", bus.dvalid, 0);
    chk("mr_dout",   bus.dout,   0);
    chk("mr_perr",   bus.perr,   0);
    chk("mr_sready", bus.sready, 1);
`ifdef JPARITY_ERRCNT_EN
    chk("mr_errcnt", errcnt, 0);
`endif
    @(negedge clk);
    rst_n      = 1'b1;
    bus.dready = 1'b1;
    send_frame(4'b0011, 1'b0);
    bus.svalid = 1'b0;
    chk("mr_after_dvalid", bus.dvalid, 1);
    chk("mr_after_dout",   bus.dout,   4'b0011);
    chk("mr_after_perr",   bus.perr,   0);
    @(negedge clk);

    // 300 bad-parity frames: error counter saturates
    for (int k = 0; k < 300; k++) begin
      send_frame(4'b0001, 1'b0);
`ifdef JPARITY_ERRCNT_EN
      if (k == 253) chk("sat_errcnt_254", errcnt, 254);
      if (k == 254) chk("sat_errcnt_255", errcnt, 255);
`endif
    end
    bus.svalid = 1'b0;
    chk("sat_dvalid", bus.dvalid, 1);
    chk("sat_dout",   bus.dout,   4'b0001);
    chk("sat_perr",   bus.perr,   1);
`ifdef JPARITY_ERRCNT_EN
    chk("sat_errcnt_final", errcnt, 255);
`endif
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
